keypad_encoder: RTL and testbench

- Producer side of the calculator input interface: scans a physical key matrix, debounces it, and encodes one key press into one `IC_ command.
- Drives in_cmd into the controller and holds each command until the controller returns in_ack.
- Sits between the board key matrix and the controller's in_cmd/in_ack pins; one command per physical press, no auto-repeat.

---
 rtl/keypad_encoder.sv | 256 +++++++++++++++++++++++++
 tb/tb_keypad_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// keypad_encoder
//   Scans an active-low key matrix one column at a time, debounces whole
//   scan frames, and turns one accepted key press into one command word for
//   the controller. The command is held until the controller acknowledges it.
//   The key must then be released for DEBOUNCE frames before another press
//   is accepted.
//
// Ports
//   Clock    in   system clock, rising edge
//   Reset    in   synchronous, active-low reset
//   key_col  out  column drive, active-low, exactly one bit low
//   key_row  in   row sense, active-low, already synchronised
//   in_cmd   out  command to controller, IC_NONE when idle
//   in_ack   in   controller consumed in_cmd this cycle
//   busy     out  high while a press is being debounced, issued or released

`ifndef IC_N
`define IC_N    5
`define IC_NONE 5'd0
`define IC_D0   5'd1
`define IC_D1   5'd2
`define IC_D2   5'd3
`define IC_D3   5'd4
`define IC_D4   5'd5
`define IC_D5   5'd6
`define IC_D6   5'd7
`define IC_D7   5'd8
`define IC_D8   5'd9
`define IC_D9   5'd10
`define IC_EXAD 5'd11
`define IC_EXSB 5'd12
`define IC_EXMU 5'd13
`define IC_EXDI 5'd14
`define IC_EXLP 5'd15
`define IC_EXRP 5'd16
`define IC_EXOK 5'd17
`define IC_CLBK 5'd18
`define IC_CLCL 5'd19
`endif

module keypad_encoder #(
  parameter int ROWS     = 4,
  parameter int COLS     = 5,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  output logic [COLS-1:0]  key_col,
  input  logic [ROWS-1:0]  key_row,
  output logic [`IC_N-1:0] in_cmd,
  input  logic             in_ack,
  output logic             busy
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KEY_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_ISSUE, S_WAIT_REL} state_t;

  state_t             r_state, w_state_nxt;
  logic [SLOT_W-1:0]  r_slot;
  logic [COL_W-1:0]   r_col_idx;
  logic [1:0]         r_acc_n;     // lows seen so far this frame: 0, 1, 2 = many
  logic [KEY_W-1:0]   r_acc_key;
  logic [KEY_W-1:0]   r_cand, w_cand_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;

  logic               w_sample, w_frame_end, w_none, w_single, w_cnt_done;
  logic [1:0]         w_col_n, w_tot_n;
  logic [ROW_W-1:0]   w_col_row;
  logic [KEY_W-1:0]   w_col_key, w_tot_key;

  function automatic logic [`IC_N-1:0] f_map(input logic [KEY_W-1:0] k);
    int unsigned idx;
    idx = 32'(k);
    case (idx)
      0:       f_map = `IC_D0;
      1:       f_map = `IC_D1;
      2:       f_map = `IC_D2;
      3:       f_map = `IC_D3;
      4:       f_map = `IC_D4;
      5:       f_map = `IC_D5;
      6:       f_map = `IC_D6;
      7:       f_map = `IC_D7;
      8:       f_map = `IC_D8;
      9:       f_map = `IC_D9;
      10:      f_map = `IC_EXAD;
      11:      f_map = `IC_EXSB;
      12:      f_map = `IC_EXMU;
      13:      f_map = `IC_EXDI;
      14:      f_map = `IC_EXLP;
      15:      f_map = `IC_EXRP;
      16:      f_map = `IC_EXOK;
      17:      f_map = `IC_CLBK;
      18:      f_map = `IC_CLCL;
      default: f_map = `IC_NONE;
    endcase
  endfunction

  // Column scan: the row sample is taken on the last cycle of each slot.
  assign w_sample    = (r_slot == SLOT_W'(SCAN_DIV - 1));
  assign w_frame_end = w_sample && (r_col_idx == COL_W'(COLS - 1));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_slot    <= '0;
      r_col_idx <= '0;
    end else if (w_sample) begin
      r_slot    <= '0;
      r_col_idx <= (r_col_idx == COL_W'(COLS - 1)) ? '0 : r_col_idx + 1'b1;
    end else begin
      r_slot    <= r_slot + 1'b1;
    end
  end

  always_comb begin
    key_col            = '1;
    key_col[r_col_idx] = 1'b0;
  end

  // Low rows in the currently driven column.
  always_comb begin
    w_col_n   = 2'd0;
    w_col_row = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!key_row[r]) begin
        if (w_col_n == 2'd0) begin
          w_col_n   = 2'd1;
          w_col_row = ROW_W'(r);
        end else begin
          w_col_n   = 2'd2;
        end
      end
    end
  end

  assign w_col_key = KEY_W'(int'(r_col_idx) * ROWS + int'(w_col_row));

  // Merge this column into the frame so far; column 0 starts a fresh frame,
  // so the frame-end result includes the last column without an extra cycle.
  always_comb begin
    if (r_col_idx == '0 || r_acc_n == 2'd0) begin
      w_tot_n   = w_col_n;
      w_tot_key = w_col_key;
    end else if (w_col_n == 2'd0) begin
      w_tot_n   = r_acc_n;
      w_tot_key = r_acc_key;
    end else begin
      w_tot_n   = 2'd2;
      w_tot_key = r_acc_key;
    end
  end

  assign w_none   = (w_tot_n == 2'd0);
  assign w_single = (w_tot_n == 2'd1);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_acc_n   <= '0;
      r_acc_key <= '0;
    end else if (w_sample) begin
      r_acc_n   <= w_tot_n;
      r_acc_key <= w_tot_key;
    end
  end

  // Saturating frame counter; every entry into IDLE clears it, so the IDLE
  // increment always yields 1 and DEBOUNCE == 1 accepts on the first frame.
  assign w_cnt_inc  = (r_cnt == CNT_W'(DEBOUNCE)) ? r_cnt : r_cnt + 1'b1;
  assign w_cnt_done = (w_cnt_inc == CNT_W'(DEBOUNCE));

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    case (r_state)
      S_IDLE: begin
        if (w_frame_end && w_single) begin
          w_cand_nxt = w_tot_key;
          if (w_cnt_done) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (f_map(w_tot_key) != `IC_NONE) ? S_ISSUE : S_WAIT_REL;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = S_DEB;
          end
        end
      end
      S_DEB: begin
        if (w_frame_end) begin
          if (w_single && (w_tot_key == r_cand)) begin
            if (w_cnt_done) begin
              w_cnt_nxt   = '0;
              w_state_nxt = (f_map(r_cand) != `IC_NONE) ? S_ISSUE : S_WAIT_REL;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_ISSUE: begin
        if (in_ack) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (w_frame_end) begin
          if (w_none) begin
            if (w_cnt_done) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    in_cmd = `IC_NONE;
    busy   = (r_state != S_IDLE);
    if (r_state == S_ISSUE) in_cmd = f_map(r_cand);
  end

endmodule

// File: tb/tb_keypad_encoder.sv
`ifndef IC_N
`define IC_N    5
`define IC_NONE 5'd0
`define IC_D0   5'd1
`define IC_D1   5'd2
`define IC_D2   5'd3
`define IC_D3   5'd4
`define IC_D4   5'd5
`define IC_D5   5'd6
`define IC_D6   5'd7
`define IC_D7   5'd8
`define IC_D8   5'd9
`define IC_D9   5'd10
`define IC_EXAD 5'd11
`define IC_EXSB 5'd12
`define IC_EXMU 5'd13
`define IC_EXDI 5'd14
`define IC_EXLP 5'd15
`define IC_EXRP 5'd16
`define IC_EXOK 5'd17
`define IC_CLBK 5'd18
`define IC_CLCL 5'd19
`endif

module tb_keypad_encoder;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [4:0]       key_col;
  logic [3:0]       key_row;
  logic [`IC_N-1:0] in_cmd;
  logic             in_ack;
  logic             busy;
  logic [19:0]      held;

  int checks   = 0;
  int failures = 0;

  keypad_encoder #(.ROWS(4), .COLS(5), .SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .key_col(key_col),
    .key_row(key_row),
    .in_cmd (in_cmd),
    .in_ack (in_ack),
    .busy   (busy)
  );

  always #5 Clock = ~Clock;

  // Key matrix model: a held key at index k = col*4 + row pulls its row
  // low while its column is driven.
  always_comb begin
    key_row = '1;
    for (int k = 0; k < 20; k++)
      if (held[k] && !key_col[k / 4]) key_row[k % 4] = 1'b0;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the bench in cycle 0: counters just cleared, Reset released.
  task automatic do_reset();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    held   = '0;
    in_ack = 1'b0;
    do_reset();
    checks++;
    if (key_col !== 5'b11110) begin failures++; $display("FAIL reset_col got=%b exp=%b", key_col, 5'b11110); end
    checks++;
    if (in_cmd !== `IC_NONE) begin failures++; $display("FAIL reset_cmd got=%0d exp=%0d", in_cmd, `IC_NONE); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    run(4);
    checks++;
    if (key_col !== 5'b11101) begin failures++; $display("FAIL scan_col1 got=%b exp=%b", key_col, 5'b11101); end
    run(12);
    checks++;
    if (key_col !== 5'b01111) begin failures++; $display("FAIL scan_col4 got=%b exp=%b", key_col, 5'b01111); end
    run(4);
    checks++;
    if (key_col !== 5'b11110) begin failures++; $display("FAIL scan_wrap got=%b exp=%b", key_col, 5'b11110); end
  endtask

  // Ends in cycle 240 with D7 issued and the key still held.
  task automatic test_basic_press();
    int bad;
    held    = '0;
    held[7] = 1'b1;
    in_ack  = 1'b0;
    do_reset();
    run(20);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_deb_busy got=%b exp=1", busy); end
    run(19);
    checks++;
    if (in_cmd !== `IC_NONE) begin failures++; $display("FAIL basic_early got=%0d exp=%0d", in_cmd, `IC_NONE); end
    run(1);
    checks++;
    if (in_cmd !== `IC_D7) begin failures++; $display("FAIL basic_cmd got=%0d exp=%0d", in_cmd, `IC_D7); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (in_cmd !== `IC_D7) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL basic_hold unstable_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_ack_release();
    int bad;
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    checks++;
    if (in_cmd !== `IC_NONE) begin failures++; $display("FAIL ack_cmd got=%0d exp=%0d", in_cmd, `IC_NONE); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL ack_busy got=%b exp=1", busy); end
    bad = 0;
    for (int i = 0; i < 59; i++) begin
      tick();
      if (in_cmd !== `IC_NONE || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL ack_no_repeat bad_cycles=%0d exp=0", bad); end
    held[7] = 1'b0;
    run(39);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL release_early got=%b exp=1", busy); end
    run(1);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL release_idle got=%b exp=0", busy); end
  endtask

  task automatic test_bounce();
    int cyc, issued;
    logic [`IC_N-1:0] prev;
    held     = '0;
    held[10] = 1'b1;
    in_ack   = 1'b0;
    do_reset();
    cyc    = 0;
    issued = 0;
    prev   = in_cmd;
    while (cyc < 160) begin
      tick();
      cyc++;
      held[10] = !(cyc >= 20 && cyc < 40);
      in_ack   = (cyc == 100);
      if (in_cmd === `IC_EXAD && prev !== `IC_EXAD) issued++;
      prev = in_cmd;
      if (cyc == 79) begin
        checks++;
        if (in_cmd !== `IC_NONE) begin failures++; $display("FAIL bounce_early got=%0d exp=%0d", in_cmd, `IC_NONE); end
      end
      if (cyc == 80) begin
        checks++;
        if (in_cmd !== `IC_EXAD) begin failures++; $display("FAIL bounce_cmd got=%0d exp=%0d", in_cmd, `IC_EXAD); end
      end
      if (cyc == 101) begin
        checks++;
        if (in_cmd !== `IC_NONE) begin failures++; $display("FAIL bounce_ack got=%0d exp=%0d", in_cmd, `IC_NONE); end
      end
    end
    in_ack = 1'b0;
    checks++;
    if (issued !== 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", issued); end
  endtask

  task automatic test_multi();
    int cyc, bad;
    held     = '0;
    held[3]  = 1'b1;
    held[17] = 1'b1;
    in_ack   = 1'b0;
    do_reset();
    cyc = 0;
    bad = 0;
    while (cyc < 140) begin
      tick();
      cyc++;
      if (cyc == 100) held[3] = 1'b0;
      if (cyc <= 100 && (in_cmd !== `IC_NONE || busy !== 1'b0)) bad++;
      if (cyc == 139) begin
        checks++;
        if (in_cmd !== `IC_NONE) begin failures++; $display("FAIL multi_early got=%0d exp=%0d", in_cmd, `IC_NONE); end
      end
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL multi_ignored bad_cycles=%0d exp=0", bad); end
    checks++;
    if (in_cmd !== `IC_CLBK) begin failures++; $display("FAIL multi_then_single got=%0d exp=%0d", in_cmd, `IC_CLBK); end
  endtask

  task automatic test_unused_key();
    int cyc, bad;
    held     = '0;
    held[19] = 1'b1;
    in_ack   = 1'b0;
    do_reset();
    cyc = 0;
    bad = 0;
    while (cyc < 120) begin
      tick();
      cyc++;
      if (cyc == 80) held[19] = 1'b0;
      in_ack = (cyc == 50);   // not in ISSUE, must have no effect
      if (in_cmd !== `IC_NONE) bad++;
      if (cyc >= 20 && cyc < 120 && busy !== 1'b1) bad++;
    end
    in_ack = 1'b0;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL unused_hold bad_cycles=%0d exp=0", bad); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL unused_release got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_issue();
    held     = '0;
    held[16] = 1'b1;
    in_ack   = 1'b0;
    do_reset();
    run(40);
    checks++;
    if (in_cmd !== `IC_EXOK) begin failures++; $display("FAIL rmi_cmd got=%0d exp=%0d", in_cmd, `IC_EXOK); end
    run(7);
    do_reset();
    checks++;
    if (in_cmd !== `IC_NONE) begin failures++; $display("FAIL rmi_drop got=%0d exp=%0d", in_cmd, `IC_NONE); end
    checks++;
    if (key_col !== 5'b11110) begin failures++; $display("FAIL rmi_col got=%b exp=%b", key_col, 5'b11110); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rmi_busy got=%b exp=0", busy); end
    run(39);
    checks++;
    if (in_cmd !== `IC_NONE) begin failures++; $display("FAIL rmi_early got=%0d exp=%0d", in_cmd, `IC_NONE); end
    run(1);
    checks++;
    if (in_cmd !== `IC_EXOK) begin failures++; $display("FAIL rmi_reaccept got=%0d exp=%0d", in_cmd, `IC_EXOK); end
  endtask

  initial begin
    Reset  = 1'b0;
    in_ack = 1'b0;
    held   = '0;
    run(2);
    test_reset();
    test_basic_press();
    test_ack_release();
    test_bounce();
    test_multi();
    test_unused_key();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
